divider_rv: RTL and testbench
=============================

Name: divider_rv

Overview:
- Parametrised multi-cycle integer divider; successor to the fixed 32-bit unsigned divider.
- Serves the RV32M/RV64M execute stage: DIV/DIVU/REM/REMU from one unit.
- Adds signed mode, RISC-V divide-by-zero and overflow results, a one-cycle fast path for those cases, and back-to-back issue.
- Restoring radix-2 core: quotient and remainder produced together.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- x  in  WIDTH  dividend.
- y  in  WIDTH  divisor.
- busy  out  1  operation in flight.
- valid  out  1  single-cycle pulse: q/r/dbz/ovf updated.
- dbz  out  1  last result was divide-by-zero.
- ovf  out  1  last result was signed overflow.
- q  out  WIDTH  quotient.
- r  out  WIDTH  remainder.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - busy, valid, dbz and ovf all 0.
  - q and r all zeros.
- States: IDLE, CALC, FIX.
- Accept (edge N, IDLE, start=1):
  - Latch |x|, |y| (magnitudes only when op_signed), sign_q = sx^sy, sign_r = sx.
  - busy=1.
  - Special cases go IDLE->FIX directly. Otherwise IDLE->CALC with count=WIDTH.
- CALC: one restoring step per edge (shift remainder, trial subtract, set quotient bit).
  - Steps run on edges N+1..N+WIDTH.
  - Goes to FIX when count reaches 0.
- FIX (one edge):
  - Negate q if sign_q; negate r if sign_r.
  - Register q, r, dbz, ovf.
  - valid=1, busy=0, ->IDLE.
- Latency:
  - Normal path: valid at edge N+WIDTH+1, i.e. 33 cycles for WIDTH=32.
  - Special path: valid at edge N+1; busy high for exactly one cycle.
- Divide-by-zero (y==0, either mode): q = all ones, r = x (unmodified), dbz=1, ovf=0.
- Overflow (op_signed, x = 1 followed by zeros, y = all ones): q = x, r = 0, ovf=1, dbz=0.
- Sign rules: remainder takes the dividend sign. Quotient truncates toward zero. Unsigned mode never sets ovf.
- valid is high exactly one cycle. q, r, dbz and ovf hold until the next FIX edge.
- start while busy=1 is ignored; no queuing, and operands are not resampled.
- start=1 in the valid cycle is accepted on the next edge (busy=0 there). Sustained issue rate is one op per WIDTH+2 cycles.
- Reset mid-operation aborts immediately: outputs return to reset values and no valid follows.
- x and y may change freely after the accept edge.

Decomposition:
- Package divider_pkg holds:
  - state enum div_state_e {IDLE, CALC, FIX};
  - localparam DIV_WIDTH_DEFAULT = 32;
  - function is_div_ovf(x, y, op_signed).
- One sub-module, divider_step: combinational single restoring step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
  - Makes a future radix-4 variant two instances.

Test Plan:
1. Unsigned 7/2, then 8/9: q=3 r=1, then q=0 r=8. valid exactly 33 cycles after the accept edge; busy high 33 cycles. Rerun with WIDTH=8 and 200/7: q=28 r=4, valid after 9 cycles.
2. Signed signs:
   - -7/2: q=0xFFFFFFFD r=0xFFFFFFFF.
   - 7/-2: q=0xFFFFFFFD r=1.
   - -7/-2: q=3 r=0xFFFFFFFF.
   - Each with dbz=0, ovf=0.
3. Divide-by-zero:
   - unsigned 2/0: q=0xFFFFFFFF r=2 dbz=1.
   - signed -5/0: q=0xFFFFFFFF r=0xFFFFFFFB dbz=1.
   - Both valid one edge after accept.
4. Overflow:
   - signed 0x80000000/0xFFFFFFFF: q=0x80000000 r=0 ovf=1, valid after 1 cycle.
   - same operands unsigned: q=0 r=0x80000000 ovf=0, after 33 cycles.
5. Back-to-back: start held high with 15/5 then operands switched to 1/1 while busy. Only 15/5 result (q=3 r=0) from the first op. Second accept occurs on the edge after valid; valid pulses are 34 cycles apart.
6. Reset mid-op: rst_n low 10 cycles into 15/5. busy, valid, q, r and dbz go 0 asynchronously; no valid after release; a fresh 1/1 then gives q=1 r=0.

Source files
------------

// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg : shared types, defaults and special-case helper for divider_rv
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Operands arrive zero-extended to 64 bits; width selects the live slice.
  function automatic logic is_div_ovf(input logic [63:0] x,
                                      input logic [63:0] y,
                                      input logic        op_signed,
                                      input int          width);
    logic [63:0] mask;
    logic [63:0] msb;
    mask = {64{1'b1}} >> (64 - width);
    msb  = 64'd1 << (width - 1);
    return op_signed && (x == msb) && (y == mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider_step.sv
// ---------------------------------------------------------------------------
// divider_step : one combinational restoring radix-2 division step
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisor_ext;

  assign shifted     = {rem_in, bit_in};
  assign divisor_ext = {1'b0, divisor};
  assign q_bit       = (shifted >= divisor_ext);
  // rem_in < divisor, so a successful trial difference always fits WIDTH bits
  assign rem_out     = q_bit ? WIDTH'(shifted - divisor_ext) : shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/divider_rv.sv
// ---------------------------------------------------------------------------
// divider_rv : multi-cycle signed/unsigned integer divider with RISC-V results
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divider_rv
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state;
  div_state_e       state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] x_raw;
  logic             sign_q;
  logic             sign_r;
  logic             sp_dbz;
  logic             sp_ovf;

  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic             dbz_case;
  logic             ovf_case;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign x_neg    = op_signed & x[WIDTH-1];
  assign y_neg    = op_signed & y[WIDTH-1];
  assign x_mag    = x_neg ? -x : x;
  assign y_mag    = y_neg ? -y : y;
  assign dbz_case = (y == '0);
  assign ovf_case = is_div_ovf(64'(x), 64'(y), op_signed, WIDTH);
  assign busy     = (state != IDLE);

  // dvd shifts the dividend out of its top and collects quotient bits at the bottom
  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .divisor (dsr),
    .bit_in  (dvd[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (dbz_case | ovf_case) ? FIX : CALC;
      CALC:    if (count == CNT_W'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      x_raw  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      sp_dbz <= 1'b0;
      sp_ovf <= 1'b0;
      valid  <= 1'b0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
      q      <= '0;
      r      <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count  <= CNT_W'(WIDTH);
            dvd    <= x_mag;
            dsr    <= y_mag;
            rem    <= '0;
            x_raw  <= x;
            sign_q <= x_neg ^ y_neg;
            sign_r <= x_neg;
            sp_dbz <= dbz_case;
            sp_ovf <= ovf_case;
          end
        end
        CALC: begin
          dvd   <= {dvd[WIDTH-2:0], step_q};
          rem   <= step_rem;
          count <= count - CNT_W'(1);
        end
        FIX: begin
          valid <= 1'b1;
          dbz   <= sp_dbz;
          ovf   <= sp_ovf;
          if (sp_dbz) begin
            q <= '1;
            r <= x_raw;
          end else if (sp_ovf) begin
            q <= x_raw;
            r <= '0;
          end else begin
            q <= sign_q ? -dvd : dvd;
            r <= sign_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_rv.sv
// ---------------------------------------------------------------------------
// tb_divider_rv : self-checking bench for divider_rv (WIDTH=32 and WIDTH=8)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_divider_rv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op_signed;
  logic [31:0] x, y, q, r;
  logic        busy, valid, dbz, ovf;

  logic        start8, op_signed8;
  logic [7:0]  x8, y8, q8, r8;
  logic        busy8, valid8, dbz8, ovf8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divider_rv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_signed(op_signed),
    .x(x), .y(y), .busy(busy), .valid(valid), .dbz(dbz), .ovf(ovf),
    .q(q), .r(r)
  );

  divider_rv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_signed(op_signed8),
    .x(x8), .y(y8), .busy(busy8), .valid(valid8), .dbz(dbz8), .ovf(ovf8),
    .q(q8), .r(r8)
  );

  // Reference: RISC-V division semantics via plain 64-bit arithmetic
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic ed, output logic eo);
    longint sa, sb;
    ed = 1'b0;
    eo = 1'b0;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; ed = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      eq = a; er = 32'd0; eo = 1'b1;
    end else if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  // Issue one op and wait for valid; lat = edges after accept, bcnt = cycles busy
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      output int lat, output int bcnt, output bit tmo);
    @(negedge clk);
    x = a; y = b; op_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = $urandom; y = $urandom; op_signed = 1'($urandom_range(0, 1));
    bcnt = busy ? 1 : 0;
    lat = 0;
    tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (valid) begin
        tmo = 1'b0;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_signed = 1'b0; x = '0; y = '0;
    start8 = 1'b0; op_signed8 = 1'b0; x8 = '0; y8 = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, valid, dbz, ovf} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {busy, valid, dbz, ovf});
    end
    total++;
    if ({q, r} !== 64'd0) begin
      bad++; $display("FAIL reset_qr: got q=%h r=%h want 0", q, r);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input int want_lat);
    int lat, bcnt;
    bit tmo;
    logic [31:0] eq, er;
    logic ed, eo;
    model(a, b, s, eq, er, ed, eo);
    op32(a, b, s, lat, bcnt, tmo);
    total++;
    if (tmo || lat != want_lat) begin
      bad++; $display("FAIL %s_latency: got %0d (timeout=%0b) want %0d", name, lat, tmo, want_lat);
    end
    total++;
    if (bcnt != want_lat) begin
      bad++; $display("FAIL %s_busy: got %0d cycles want %0d", name, bcnt, want_lat);
    end
    total++;
    if ({q, r, dbz, ovf} !== {eq, er, ed, eo}) begin
      bad++; $display("FAIL %s_result: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                      name, q, r, dbz, ovf, eq, er, ed, eo);
    end
  endtask

  task automatic test_unsigned();
    test_fixed("u_7_2", 32'd7, 32'd2, 1'b0, 33);
    total++;
    if ({q, r} !== {32'd3, 32'd1}) begin
      bad++; $display("FAIL u_7_2_const: got q=%0d r=%0d want q=3 r=1", q, r);
    end
    test_fixed("u_8_9", 32'd8, 32'd9, 1'b0, 33);
  endtask

  task automatic test_width8();
    int lat;
    bit tmo;
    @(negedge clk);
    x8 = 8'd200; y8 = 8'd7; op_signed8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; x8 = '0; y8 = '0;
    lat = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (valid8) begin tmo = 1'b0; break; end
    end
    total++;
    if (tmo || lat != 9) begin
      bad++; $display("FAIL w8_latency: got %0d (timeout=%0b) want 9", lat, tmo);
    end
    total++;
    if ({q8, r8, dbz8, ovf8} !== {8'd28, 8'd4, 2'b00}) begin
      bad++; $display("FAIL w8_result: got q=%0d r=%0d want q=28 r=4", q8, r8);
    end
  endtask

  task automatic test_signed();
    test_fixed("s_m7_2",  32'hFFFF_FFF9, 32'd2,        1'b1, 33);
    test_fixed("s_7_m2",  32'd7,         32'hFFFF_FFFE, 1'b1, 33);
    test_fixed("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 33);
  endtask

  task automatic test_special();
    test_fixed("dbz_u",   32'd2,         32'd0,         1'b0, 1);
    test_fixed("dbz_s",   32'hFFFF_FFFB, 32'd0,         1'b1, 1);
    test_fixed("ovf_s",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
    test_fixed("ovf_u",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33);
  endtask

  task automatic test_valid_pulse();
    logic [31:0] hq, hr;
    test_fixed("pulse_op", 32'd100, 32'd7, 1'b0, 33);
    hq = q; hr = r;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (valid !== 1'b0 || {q, r} !== {hq, hr}) begin
        bad++; $display("FAIL valid_hold: got valid=%b q=%h r=%h want valid=0 q=%h r=%h",
                        valid, q, r, hq, hr);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    int kind;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 5);
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case (kind)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      test_fixed($sformatf("rand%0d", n), a, b, s,
                 (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    bit tmo;
    @(negedge clk);
    x = 32'd15; y = 32'd5; op_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    x = 32'd1; y = 32'd1;
    lat = 0; tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (valid) begin tmo = 1'b0; break; end
    end
    total++;
    if (tmo || lat != 33) begin
      bad++; $display("FAIL b2b_first_latency: got %0d (timeout=%0b) want 33", lat, tmo);
    end
    total++;
    if ({q, r} !== {32'd3, 32'd0}) begin
      bad++; $display("FAIL b2b_first_result: got q=%0d r=%0d want q=3 r=0", q, r);
    end
    gap = 0; tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) start = 1'b0;
      if (valid) begin tmo = 1'b0; break; end
    end
    total++;
    if (tmo || gap != 34) begin
      bad++; $display("FAIL b2b_gap: got %0d (timeout=%0b) want 34", gap, tmo);
    end
    total++;
    if ({q, r} !== {32'd1, 32'd0}) begin
      bad++; $display("FAIL b2b_second_result: got q=%0d r=%0d want q=1 r=0", q, r);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    x = 32'd15; y = 32'd5; op_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, valid, dbz, ovf} !== 4'b0000 || {q, r} !== 64'd0) begin
      bad++; $display("FAIL midreset_clear: got busy=%b valid=%b dbz=%b ovf=%b q=%h r=%h want all 0",
                      busy, valid, dbz, ovf, q, r);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL midreset_no_valid: got activity=%b want 0", seen);
    end
    test_fixed("after_reset_1_1", 32'd1, 32'd1, 1'b0, 33);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_width8();
    test_signed();
    test_special();
    test_valid_pulse();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
